// File: rtl/pp_pipeline_accel_normalize_stage.sv
// pp_pipeline_accel_normalize_stage
// Frame-oriented normalisation stage that sits between two stream FIFOs.
// It pops unsigned IN_W-bit samples, computes
//   y = sat(((x - mean) * scale + 2^(SHIFT-1)) >>> SHIFT)
// and pushes OUT_W-bit results downstream. Block-level control follows the
// usual ap_start / ap_done / ap_idle / ap_ready protocol, one frame per start.
//
// Stream handshake (both FIFO sides):
//   Read side : a sample transfers in every cycle where in_read=1. in_read is
//               only raised while in_empty_n=1, and in_dout is captured into
//               stage 1 in that same cycle.
//   Write side: a result transfers in every cycle where out_write=1.
//               out_write is only raised while out_full_n=1. When stage 3 holds
//               a result and out_full_n=0 the whole pipe freezes, so out_din
//               and the pending write stay unchanged until space appears.
//               Nothing is dropped or duplicated.
module pp_pipeline_accel_normalize_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 8,
    parameter int CNT_W = 24
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    input  logic [CNT_W-1:0] pixel_count,
    input  logic [IN_W-1:0]  mean,
    input  logic [15:0]      scale,
    input  logic             in_empty_n,
    output logic             in_read,
    input  logic [IN_W-1:0]  in_dout,
    input  logic             out_full_n,
    output logic             out_write,
    output logic [OUT_W-1:0] out_din,
    output logic [1:0]       dbg_state
);

    // Datapath widths: difference of two unsigned IN_W values needs one extra
    // bit; the product with the 16-bit signed gain needs the sum of widths.
    localparam int DIFF_W = IN_W + 1;
    localparam int PROD_W = DIFF_W + 16;

    // Rounding constant 2^(SHIFT-1) and the saturation ceiling 2^OUT_W-1.
    localparam logic [PROD_W-1:0] ROUND_C = {{(PROD_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic [PROD_W-1:0] OUT_MAX = {{(PROD_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    // Frame control states.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state;
    logic [1:0]              state_d;

    // Frame parameters captured at start so the host may change them mid-frame.
    logic [CNT_W-1:0]        cnt_q;
    logic [IN_W-1:0]         mean_q;
    logic signed [15:0]      scale_q;

    // Per-frame progress counters.
    logic [CNT_W-1:0]        rd_cnt;
    logic [CNT_W-1:0]        wr_cnt;
    logic [CNT_W:0]          rd_cnt_inc;
    logic [CNT_W:0]          wr_cnt_inc;

    // Pipeline valid bits and stage registers.
    logic                    v1;
    logic                    v2;
    logic                    v3;
    logic signed [DIFF_W-1:0] d1;
    logic signed [PROD_W-1:0] p2;
    logic [OUT_W-1:0]        r3;

    // Combinational datapath values feeding each stage register.
    logic signed [DIFF_W-1:0] diff_c;
    logic signed [PROD_W-1:0] d1_x;
    logic signed [PROD_W-1:0] scale_x;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] sum_c;
    logic signed [PROD_W-1:0] shr_c;
    logic [OUT_W-1:0]         sat_c;

    // Control helpers.
    logic                    stall;
    logic                    rd_more;
    logic                    last_read;
    logic                    last_write;
    logic                    pipe_empty;
    logic                    drain_done;
    logic                    start_frame;

    // ------------------------------------------------------------------
    // Handshake and status decode
    // ------------------------------------------------------------------

    // Stage 3 holding a result the downstream FIFO cannot accept freezes
    // every stage and the upstream pop.
    assign stall       = v3 & ~out_full_n;

    assign rd_more     = (rd_cnt < cnt_q);
    assign in_read     = (state == S_RUN) & in_empty_n & rd_more & ~stall;
    assign out_write   = v3 & out_full_n;
    assign out_din     = r3;

    assign rd_cnt_inc  = {1'b0, rd_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign wr_cnt_inc  = {1'b0, wr_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // The final pop / push of the frame, recognised in the cycle it happens.
    assign last_read   = in_read & (rd_cnt_inc == {1'b0, cnt_q});
    assign last_write  = out_write & (wr_cnt_inc == {1'b0, cnt_q});

    assign pipe_empty  = ~v1 & ~v2 & ~v3;

    // Leaving DRAIN in the cycle of the final push makes ap_done land in the
    // very next cycle; the second term covers an already-settled pipe.
    assign drain_done  = last_write | ((wr_cnt == cnt_q) & pipe_empty);

    assign start_frame = (state == S_IDLE) & ap_start;

    assign ap_idle     = (state == S_IDLE);
    assign ap_done     = (state == S_DONE);

    // An empty frame never reads, so ap_ready is reported alongside ap_done.
    assign ap_ready    = last_read | ((state == S_DONE) & (cnt_q == '0));

    assign dbg_state   = state;

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------

    // Stage 1 input: zero-extend both operands, subtract as signed.
    assign diff_c  = $signed({1'b0, in_dout}) - $signed({1'b0, mean_q});

    // Stage 2 input: sign-extend to the full product width so the multiply is
    // exact and signed.
    assign d1_x    = {{(PROD_W-DIFF_W){d1[DIFF_W-1]}}, d1};
    assign scale_x = {{(PROD_W-16){scale_q[15]}}, scale_q};
    assign prod_c  = d1_x * scale_x;

    // Stage 3 input: round half up, then arithmetic shift drops the fraction.
    assign sum_c   = p2 + $signed(ROUND_C);
    assign shr_c   = sum_c >>> SHIFT;

    // Clamp the shifted value into the unsigned output range.
    always_comb begin
        sat_c = shr_c[OUT_W-1:0];
        if (shr_c[PROD_W-1]) begin
            sat_c = '0;
        end else if (shr_c > $signed(OUT_MAX)) begin
            sat_c = '1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------

    // Next-state selection for the frame controller.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = (pixel_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_read) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, frame parameter capture and progress counters.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state   <= S_IDLE;
            cnt_q   <= '0;
            mean_q  <= '0;
            scale_q <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
        end else begin
            state <= state_d;
            if (start_frame) begin
                cnt_q   <= pixel_count;
                mean_q  <= mean;
                scale_q <= scale;
                rd_cnt  <= '0;
                wr_cnt  <= '0;
            end else begin
                if (in_read) begin
                    rd_cnt <= rd_cnt_inc[CNT_W-1:0];
                end
                if (out_write) begin
                    wr_cnt <= wr_cnt_inc[CNT_W-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Three-stage pipeline
    // ------------------------------------------------------------------

    // All stages advance together unless the output is blocked; data registers
    // only load behind a valid so out_din stays quiet between frames.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            d1 <= '0;
            p2 <= '0;
            r3 <= '0;
        end else if (!stall) begin
            v1 <= in_read;
            v2 <= v1;
            v3 <= v2;
            if (in_read) begin
                d1 <= diff_c;
            end
            if (v1) begin
                p2 <= prod_c;
            end
            if (v2) begin
                r3 <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_normalize_stage.sv
// tb_pp_pipeline_accel_normalize_stage
// Directed frames with hand-computed results: identity, saturation, rounding,
// offset/gain, output backpressure, empty frame and reset in mid-frame.
module tb_pp_pipeline_accel_normalize_stage;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int SHIFT = 8;
    localparam int CNT_W = 24;

    // ---------------- clock / reset ----------------
    logic             ap_clk;
    logic             ap_rst_n;
    logic             ap_start;
    logic             ap_done;
    logic             ap_idle;
    logic             ap_ready;
    logic [CNT_W-1:0] pixel_count;
    logic [IN_W-1:0]  mean;
    logic [15:0]      scale;
    logic             in_empty_n;
    logic             in_read;
    logic [IN_W-1:0]  in_dout;
    logic             out_full_n;
    logic             out_write;
    logic [OUT_W-1:0] out_din;
    logic [1:0]       dbg_state;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    pp_pipeline_accel_normalize_stage #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT),
        .CNT_W(CNT_W)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .pixel_count(pixel_count),
        .mean       (mean),
        .scale      (scale),
        .in_empty_n (in_empty_n),
        .in_read    (in_read),
        .in_dout    (in_dout),
        .out_full_n (out_full_n),
        .out_write  (out_write),
        .out_din    (out_din),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    logic [OUT_W-1:0] exp_q[$];
    logic [IN_W-1:0]  src_q[$];
    bit               mon_en = 1'b0;
    bit               bp_en  = 1'b0;
    bit               bv1 = 1'b0, bv2 = 1'b0, bv3 = 1'b0;
    bit               prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_din = '0;
    int               nrd, nwr, first_rd, first_wr, last_rd, last_wr;
    int               ready_cyc, done_cyc, n_ready, n_done, n_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void clear_stats();
        nrd = 0; nwr = 0; first_rd = -1; first_wr = -1; last_rd = -1; last_wr = -1;
        ready_cyc = -1; done_cyc = -1; n_ready = 0; n_done = 0; n_stall = 0;
    endfunction

    // ---------------- driver tasks ----------------
    // Upstream FIFO model: head of src_q is presented while it is non-empty.
    task automatic drive_src();
        if (src_q.size() > 0) begin
            in_empty_n = 1'b1;
            in_dout    = src_q[0];
        end else begin
            in_empty_n = 1'b0;
            in_dout    = '0;
        end
    endtask

    // One clock: sample and check at the falling edge, then update the
    // FIFO model and drive new inputs just after the rising edge.
    task automatic tick();
        bit s_rd, s_wr, s_ofn, stall_m;
        @(negedge ap_clk);
        cyc++;
        s_rd    = (in_read === 1'b1);
        s_wr    = (out_write === 1'b1);
        s_ofn   = out_full_n;
        stall_m = bv3 & ~s_ofn;
        if (mon_en) begin
            check("out_write_model", {31'd0, out_write}, {31'd0, bv3 & s_ofn});
            if (stall_m) check("no_read_in_stall", {31'd0, in_read}, 32'd0);
            if (s_rd) check("read_needs_data", {31'd0, in_empty_n}, 32'd1);
            if (prev_stall && bv3) check("din_hold", {24'd0, out_din}, {24'd0, prev_din});
            if (stall_m) n_stall++;
            if (s_rd) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                nrd++;
            end
            if (s_wr) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                nwr++;
                if (exp_q.size() == 0) check("spurious_write", {31'd0, out_write}, 32'd0);
                else check("out_din", {24'd0, out_din}, {24'd0, exp_q.pop_front()});
            end
            if (ap_ready === 1'b1) begin n_ready++; ready_cyc = cyc; end
            if (ap_done === 1'b1) begin n_done++; done_cyc = cyc; end
        end
        prev_stall = stall_m;
        prev_din   = out_din;
        @(posedge ap_clk);
        if (!ap_rst_n) begin
            bv1 = 1'b0; bv2 = 1'b0; bv3 = 1'b0;
        end else if (!stall_m) begin
            bv3 = bv2; bv2 = bv1; bv1 = s_rd;
        end
        #1;
        if (s_rd && src_q.size() > 0) void'(src_q.pop_front());
        drive_src();
        out_full_n = bp_en ? (((cyc % 4) < 2) ? 1'b0 : 1'b1) : 1'b1;
    endtask

    // Start a frame and run it to ap_done, then check frame-level timing.
    task automatic run_frame(input int cnt, input logic [15:0] m, input logic [15:0] sc,
                             input int budget);
        int start_cyc;
        int k;
        clear_stats();
        check("idle_before_start", {31'd0, ap_idle}, 32'd1);
        pixel_count = CNT_W'(cnt);
        mean        = m;
        scale       = sc;
        ap_start    = 1'b1;
        drive_src();
        tick();
        start_cyc = cyc;
        ap_start  = 1'b0;
        k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        check("done_pulses", n_done, 1);
        check("ready_pulses", n_ready, 1);
        check("reads", nrd, cnt);
        check("writes", nwr, cnt);
        check("queue_drained", exp_q.size(), 0);
        if (cnt == 0) begin
            check("zero_ready_cycle", ready_cyc, start_cyc + 1);
            check("zero_done_cycle", done_cyc, start_cyc + 1);
        end else begin
            check("first_read", first_rd, start_cyc + 1);
            check("ready_with_last_read", ready_cyc, last_rd);
            check("done_after_last_write", done_cyc, last_wr + 1);
        end
        tick();
        check("idle_after_done", {31'd0, ap_idle}, 32'd1);
        check("done_low_after", {31'd0, ap_done}, 32'd0);
        check("done_one_cycle", n_done, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        ap_rst_n    = 1'b0;
        ap_start    = 1'b0;
        pixel_count = '0;
        mean        = '0;
        scale       = '0;
        in_empty_n  = 1'b0;
        in_dout     = '0;
        out_full_n  = 1'b1;
        clear_stats();

        repeat (3) tick();
        ap_rst_n = 1'b1;
        check("rst_idle", {31'd0, ap_idle}, 32'd1);
        check("rst_done", {31'd0, ap_done}, 32'd0);
        check("rst_ready", {31'd0, ap_ready}, 32'd0);
        check("rst_in_read", {31'd0, in_read}, 32'd0);
        check("rst_out_write", {31'd0, out_write}, 32'd0);
        check("rst_out_din", {24'd0, out_din}, 32'd0);
        mon_en = 1'b1;

        // Identity gain.
        src_q = '{16'd10, 16'd20, 16'd200, 16'd255};
        exp_q = '{8'd10, 8'd20, 8'd200, 8'd255};
        run_frame(4, 16'd0, 16'h0100, 60);
        check("id_latency", first_wr - first_rd, 3);
        check("id_ready_at_4th_read", ready_cyc, first_rd + 3);
        check("id_done_cycle", done_cyc, first_rd + 7);

        // Saturation at both ends.
        src_q = '{16'd50, 16'd100, 16'd300};
        exp_q = '{8'd0, 8'd0, 8'd255};
        run_frame(3, 16'd100, 16'h0200, 60);

        // Round half up: 1.5 -> 2, 2.5 -> 3.
        src_q = '{16'd3, 16'd5};
        exp_q = '{8'd2, 8'd3};
        run_frame(2, 16'd0, 16'h0080, 60);

        // Offset with gain 1.5: (116-16)*1.5=150, (17-16)*1.5=1.5 -> 2.
        src_q = '{16'd116, 16'd17};
        exp_q = '{8'd150, 8'd2};
        run_frame(2, 16'd16, 16'h0180, 60);

        // Output backpressure toggling every two cycles.
        src_q = '{16'd30, 16'd60, 16'd90, 16'd120, 16'd150, 16'd180, 16'd210, 16'd240};
        exp_q = '{8'd30, 8'd60, 8'd90, 8'd120, 8'd150, 8'd180, 8'd210, 8'd240};
        bp_en = 1'b1;
        run_frame(8, 16'd0, 16'h0100, 200);
        check("bp_stalls_seen", {31'd0, n_stall > 0}, 32'd1);
        bp_en      = 1'b0;
        out_full_n = 1'b1;
        tick();

        // Empty frame.
        src_q.delete();
        exp_q.delete();
        run_frame(0, 16'd0, 16'h0100, 20);

        // Reset after three of eight reads.
        clear_stats();
        src_q = '{16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18};
        exp_q = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
        pixel_count = CNT_W'(8);
        mean        = '0;
        scale       = 16'h0100;
        ap_start    = 1'b1;
        drive_src();
        tick();
        ap_start = 1'b0;
        for (int k = 0; k < 20 && nrd < 3; k++) tick();
        check("mid_three_reads", nrd, 3);
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        check("mid_idle", {31'd0, ap_idle}, 32'd1);
        check("mid_in_read", {31'd0, in_read}, 32'd0);
        check("mid_out_write", {31'd0, out_write}, 32'd0);
        check("mid_out_din", {24'd0, out_din}, 32'd0);
        exp_q.delete();
        repeat (4) tick();
        check("mid_no_done", n_done, 0);
        check("mid_no_more_reads", nrd, 4);

        // Fresh frame after the abandoned one.
        src_q = '{16'd40, 16'd80};
        exp_q = '{8'd40, 8'd80};
        run_frame(2, 16'd0, 16'h0100, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
